// File: rtl/vga_axil_pkg.sv
// vga_axil_pkg: types and constants shared by the VGA AXI4-Lite register file.
// Contents: bus data/address types, AXI response codes, register byte offsets,
// one-hot register select indices, FSM state types and the CTRL register layout.
package vga_axil_pkg;

    typedef logic [31:0] axil_addr_t;
    typedef logic [31:0] axil_data_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axil_resp_e;

    // Byte offsets, decoded on addr[7:0]
    localparam logic [7:0] REG_CTRL      = 8'h00;
    localparam logic [7:0] REG_STATUS    = 8'h04;
    localparam logic [7:0] REG_FRAME_CNT = 8'h08;
    localparam logic [7:0] REG_IRQ_CLR   = 8'h0C;
    localparam logic [7:0] REG_FB_BASE   = 8'h10;
    localparam logic [7:0] REG_ID        = 8'h14;

    // Bit positions in the one-hot register select
    localparam int unsigned REG_NUM       = 6;
    localparam int unsigned SEL_CTRL      = 0;
    localparam int unsigned SEL_STATUS    = 1;
    localparam int unsigned SEL_FRAME_CNT = 2;
    localparam int unsigned SEL_IRQ_CLR   = 3;
    localparam int unsigned SEL_FB_BASE   = 4;
    localparam int unsigned SEL_ID        = 5;

    typedef struct packed {
        logic       irq_en;
        logic [1:0] pattern;
        logic       enable;
    } ctrl_reg_t;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

endpackage

// File: rtl/vga_axil_if.sv
// vga_axil_if: AXI4-Lite bus bundle between the VGA bus front end and the
// register file.
// Modports: master drives addresses, write data, valids and response readies;
// slave drives address/data readies and the B/R response channels.
interface vga_axil_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/vga_axil_regs_decode.sv
// vga_axil_regs_decode: combinational register offset decode.
// Ports: offset (addr[7:0]) in; sel one-hot register select, is_writable,
// is_readable and err (misaligned or unmapped offset) out. sel is all-zero
// whenever err is set.
module vga_axil_regs_decode
    import vga_axil_pkg::*;
(
    input  logic [7:0]         offset,
    output logic [REG_NUM-1:0] sel,
    output logic               is_writable,
    output logic               is_readable,
    output logic               err
);
    always_comb begin
        sel         = '0;
        is_writable = 1'b0;
        is_readable = 1'b0;
        err         = 1'b0;
        if (offset[1:0] != 2'b00) begin
            err = 1'b1;
        end else begin
            case (offset)
                REG_CTRL: begin
                    sel[SEL_CTRL] = 1'b1;
                    is_readable   = 1'b1;
                    is_writable   = 1'b1;
                end
                REG_STATUS: begin
                    sel[SEL_STATUS] = 1'b1;
                    is_readable     = 1'b1;
                end
                REG_FRAME_CNT: begin
                    sel[SEL_FRAME_CNT] = 1'b1;
                    is_readable        = 1'b1;
                end
                REG_IRQ_CLR: begin
                    // Write-only in effect, but reads are legal and return 0
                    sel[SEL_IRQ_CLR] = 1'b1;
                    is_readable      = 1'b1;
                    is_writable      = 1'b1;
                end
                REG_FB_BASE: begin
                    sel[SEL_FB_BASE] = 1'b1;
                    is_readable      = 1'b1;
                    is_writable      = 1'b1;
                end
                REG_ID: begin
                    sel[SEL_ID] = 1'b1;
                    is_readable = 1'b1;
                end
                default: err = 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/vga_axil_regs.sv
// vga_axil_regs: AXI4-Lite slave register file for the VGA core.
// Ports: clk, rst (sync, active-high); axi (vga_axil_if slave modport);
// frame_start_i (per-frame strobe), in_vblank_i (vblank level);
// enable_o, pattern_sel_o, fb_base_o (static config); irq_o (registered
// frame_irq & irq_en).
// Registers: CTRL 0x00, STATUS 0x04, FRAME_CNT 0x08, IRQ_CLR 0x0C,
// FB_BASE 0x10, ID 0x14. Independent write (IDLE/DATA/RESP) and read
// (IDLE/DATA) FSMs, one outstanding transaction each.
module vga_axil_regs
    import vga_axil_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter logic [31:0] ID_VALUE    = 32'h5647_4101,
    parameter logic [31:0] FB_BASE_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    vga_axil_if.slave   axi,
    input  logic        frame_start_i,
    input  logic        in_vblank_i,
    output logic        enable_o,
    output logic [1:0]  pattern_sel_o,
    output logic [31:0] fb_base_o,
    output logic        irq_o
);
    w_state_e   w_state;
    r_state_e   r_state;
    logic [7:0] aw_off;

    ctrl_reg_t  ctrl;
    axil_data_t fb_base;
    axil_data_t frame_cnt;
    logic       frame_irq;

    logic [REG_NUM-1:0] w_sel, r_sel;
    logic w_writable, w_err, w_unused_rd;
    logic r_readable, r_err, r_unused_wr;
    logic w_fire, w_ok, irq_clr;
    axil_data_t rd_val;

    // Upper address bits are ignored by design
    logic unused;
    assign unused = ^{axi.awaddr, axi.araddr, ADDR_W[0]};

    vga_axil_regs_decode u_wdec (
        .offset      (aw_off),
        .sel         (w_sel),
        .is_writable (w_writable),
        .is_readable (w_unused_rd),
        .err         (w_err)
    );

    vga_axil_regs_decode u_rdec (
        .offset      (axi.araddr[7:0]),
        .sel         (r_sel),
        .is_writable (r_unused_wr),
        .is_readable (r_readable),
        .err         (r_err)
    );

    always_comb begin
        w_fire  = (w_state == W_DATA) && axi.wvalid && axi.wready;
        w_ok    = !w_err && w_writable && (axi.wstrb == '1);
        irq_clr = w_fire && w_ok && w_sel[SEL_IRQ_CLR] && axi.wdata[0];
    end

    // Write FSM: awready is held high in W_IDLE, which also makes it rise on
    // the first cycle after reset releases.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state     <= W_IDLE;
            axi.awready <= 1'b0;
            axi.wready  <= 1'b0;
            axi.bvalid  <= 1'b0;
            axi.bresp   <= OKAY;
            aw_off      <= '0;
            ctrl        <= '0;
            fb_base     <= FB_BASE_RST;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (axi.awvalid && axi.awready) begin
                        aw_off      <= axi.awaddr[7:0];
                        axi.awready <= 1'b0;
                        axi.wready  <= 1'b1;
                        w_state     <= W_DATA;
                    end else begin
                        axi.awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        if (w_ok) begin
                            if (w_sel[SEL_CTRL])    ctrl    <= ctrl_reg_t'(axi.wdata[3:0]);
                            if (w_sel[SEL_FB_BASE]) fb_base <= axi.wdata[31:0];
                        end
                        axi.bresp  <= w_ok ? OKAY : SLVERR;
                        axi.wready <= 1'b0;
                        axi.bvalid <= 1'b1;
                        w_state    <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (axi.bready) begin
                        axi.bvalid  <= 1'b0;
                        axi.awready <= 1'b1;
                        w_state     <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_val = '0;
        if (r_sel[SEL_CTRL])      rd_val = 32'(ctrl);
        if (r_sel[SEL_STATUS])    rd_val = {30'b0, frame_irq, in_vblank_i};
        if (r_sel[SEL_FRAME_CNT]) rd_val = frame_cnt;
        if (r_sel[SEL_FB_BASE])   rd_val = fb_base;
        if (r_sel[SEL_ID])        rd_val = ID_VALUE;
    end

    // Read FSM: data captured at AR handshake, so a same-edge write commit is
    // not yet visible and the old value is returned.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= R_IDLE;
            axi.arready <= 1'b0;
            axi.rvalid  <= 1'b0;
            axi.rdata   <= '0;
            axi.rresp   <= OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (axi.arvalid && axi.arready) begin
                        if (!r_err && r_readable) begin
                            axi.rdata <= DATA_W'(rd_val);
                            axi.rresp <= OKAY;
                        end else begin
                            axi.rdata <= '0;
                            axi.rresp <= SLVERR;
                        end
                        axi.arready <= 1'b0;
                        axi.rvalid  <= 1'b1;
                        r_state     <= R_DATA;
                    end else begin
                        axi.arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (axi.rready) begin
                        axi.rvalid  <= 1'b0;
                        axi.arready <= 1'b1;
                        r_state     <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Frame event tracking; a frame set outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            frame_irq <= 1'b0;
            irq_o     <= 1'b0;
        end else begin
            if (frame_start_i) frame_cnt <= frame_cnt + 32'd1;
            if (frame_start_i)  frame_irq <= 1'b1;
            else if (irq_clr)   frame_irq <= 1'b0;
            irq_o <= frame_irq & ctrl.irq_en;
        end
    end

    assign enable_o      = ctrl.enable;
    assign pattern_sel_o = ctrl.pattern;
    assign fb_base_o     = fb_base;

endmodule

// File: tb/tb_vga_axil_regs.sv
// tb_vga_axil_regs: directed self-checking bench for vga_axil_regs.
module tb_vga_axil_regs;
    import vga_axil_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        frame_start_i;
    logic        in_vblank_i;
    logic        enable_o;
    logic [1:0]  pattern_sel_o;
    logic [31:0] fb_base_o;
    logic        irq_o;

    vga_axil_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    vga_axil_regs #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .ID_VALUE    (32'h5647_4101),
        .FB_BASE_RST (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .axi           (bus),
        .frame_start_i (frame_start_i),
        .in_vblank_i   (in_vblank_i),
        .enable_o      (enable_o),
        .pattern_sel_o (pattern_sel_o),
        .fb_base_o     (fb_base_o),
        .irq_o         (irq_o)
    );

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic [1:0]  b_q[$];
    logic [33:0] r_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        tests++;
        fails++;
        $error("FAIL %s: handshake timeout, observed no response expected response within 20 cycles", tag);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] exp,
                             input bit pulse, input bit hold);
        bit ok;
        b_q.push_back(exp);
        bus.awaddr  = addr;
        bus.awvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.awready) begin ok = 1'b1; tick(); break; end
            tick();
        end
        bus.awvalid = 1'b0;
        if (!ok) begin timeout("aw"); void'(b_q.pop_front()); return; end

        bus.wdata  = data;
        bus.wstrb  = strb;
        bus.wvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.wready) begin
                ok = 1'b1;
                frame_start_i = pulse;
                tick();
                frame_start_i = 1'b0;
                break;
            end
            tick();
        end
        bus.wvalid = 1'b0;
        if (!ok) begin timeout("w"); void'(b_q.pop_front()); return; end

        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.bvalid) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) begin timeout("b"); void'(b_q.pop_front()); return; end
        check("bresp", 32'(bus.bresp), 32'(b_q.pop_front()));
        if (!hold) begin
            bus.bready = 1'b1;
            tick();
            bus.bready = 1'b0;
            check("bvalid_drop", 32'(bus.bvalid), 32'd0);
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [1:0] exp_resp,
                            input logic [31:0] exp_data);
        bit ok;
        logic [33:0] e;
        r_q.push_back({exp_resp, exp_data});
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.arready) begin ok = 1'b1; tick(); break; end
            tick();
        end
        bus.arvalid = 1'b0;
        if (!ok) begin timeout("ar"); void'(r_q.pop_front()); return; end

        bus.rready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.rvalid) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) begin timeout("r"); bus.rready = 1'b0; void'(r_q.pop_front()); return; end
        e = r_q.pop_front();
        check("rresp", 32'(bus.rresp), 32'(e[33:32]));
        check("rdata", bus.rdata, e[31:0]);
        tick();
        bus.rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.awaddr = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        frame_start_i = 1'b0;
        in_vblank_i   = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check("rst_awready", 32'(bus.awready), 32'd0);
        check("rst_arready", 32'(bus.arready), 32'd0);
        check("rst_bvalid", 32'(bus.bvalid), 32'd0);
        check("rst_rvalid", 32'(bus.rvalid), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_enable", 32'(enable_o), 32'd0);
        check("rst_fb_base", fb_base_o, 32'd0);
        check("rst_irq", 32'(irq_o), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_awready", 32'(bus.awready), 32'd1);
        check("post_rst_arready", 32'(bus.arready), 32'd1);

        // CTRL write/readback
        axi_write(32'h00, 32'h0000_0007, 4'hF, OKAY, 1'b0, 1'b0);
        axi_read(32'h00, OKAY, 32'h0000_0007);
        check("enable_o", 32'(enable_o), 32'd1);
        check("pattern_sel_o", 32'(pattern_sel_o), 32'd3);

        // FB_BASE and ID
        axi_write(32'h10, 32'h8000_0000, 4'hF, OKAY, 1'b0, 1'b0);
        check("fb_base_o", fb_base_o, 32'h8000_0000);
        axi_read(32'h10, OKAY, 32'h8000_0000);
        axi_read(32'h14, OKAY, 32'h5647_4101);

        // Frame counter, sticky IRQ, irq_en
        axi_write(32'h00, 32'h0000_0008, 4'hF, OKAY, 1'b0, 1'b0);
        check("irq_before_frames", 32'(irq_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            frame_start_i = 1'b1;
            tick();
            frame_start_i = 1'b0;
            tick();
        end
        in_vblank_i = 1'b1;
        axi_read(32'h08, OKAY, 32'd3);
        axi_read(32'h04, OKAY, 32'h0000_0003);
        check("irq_set", 32'(irq_o), 32'd1);
        in_vblank_i = 1'b0;

        // Clear racing a frame start: set wins
        axi_write(32'h0C, 32'h0000_0001, 4'hF, OKAY, 1'b1, 1'b0);
        axi_read(32'h04, OKAY, 32'h0000_0002);
        check("irq_race", 32'(irq_o), 32'd1);
        axi_write(32'h0C, 32'h0000_0001, 4'hF, OKAY, 1'b0, 1'b0);
        axi_read(32'h04, OKAY, 32'h0000_0000);
        check("irq_cleared", 32'(irq_o), 32'd0);

        // Error responses
        axi_write(32'h08, 32'h0000_0055, 4'hF, SLVERR, 1'b0, 1'b0);
        axi_read(32'h40, SLVERR, 32'h0000_0000);
        axi_write(32'h02, 32'h0000_0001, 4'hF, SLVERR, 1'b0, 1'b0);
        axi_write(32'h00, 32'h0000_0000, 4'h3, SLVERR, 1'b0, 1'b0);
        axi_write(32'h14, 32'h0000_0000, 4'hF, SLVERR, 1'b0, 1'b0);
        axi_read(32'h00, OKAY, 32'h0000_0008);
        axi_read(32'h08, OKAY, 32'd4);
        axi_read(32'h0C, OKAY, 32'h0000_0000);
        axi_read(32'h16, SLVERR, 32'h0000_0000);
        axi_read(32'h114, OKAY, 32'h5647_4101);

        // Reset while a write response is pending
        axi_write(32'h00, 32'h0000_0005, 4'hF, OKAY, 1'b0, 1'b1);
        check("hold_bvalid", 32'(bus.bvalid), 32'd1);
        check("hold_enable", 32'(enable_o), 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_bvalid", 32'(bus.bvalid), 32'd0);
        check("mid_rst_enable", 32'(enable_o), 32'd0);
        check("mid_rst_fb_base", fb_base_o, 32'd0);
        rst = 1'b0;
        tick();
        check("rerst_awready", 32'(bus.awready), 32'd1);
        axi_write(32'h00, 32'h0000_0006, 4'hF, OKAY, 1'b0, 1'b0);
        axi_read(32'h00, OKAY, 32'h0000_0006);
        check("pattern_after_rst", 32'(pattern_sel_o), 32'd3);
        check("enable_after_rst", 32'(enable_o), 32'd0);
        axi_read(32'h08, OKAY, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vga_axil_regs.md
Name: vga_axil_regs

Overview:
- AXI4-Lite slave register file for the VGA core, directly downstream of vga_axil_if, and consumes its master-side signals.
- Exposes control and status registers to software: display enable, test pattern, framebuffer base, frame counter and sticky frame IRQ.
- Drives static config into the VGA timing/pixel pipeline and samples frame events from it.
- Single outstanding transaction per channel. Address-before-data ordering. No back-to-back handshakes on any channel.

Parameters:
- ADDR_W, 32, AXI-Lite address width (32 or 64).
- DATA_W, 32, AXI-Lite data width (32 or 64); registers use bits [31:0] and upper bits read 0.
- ID_VALUE, 32'h5647_4101, constant returned by the ID register.
- FB_BASE_RST, 32'h0000_0000, reset value of FB_BASE.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- awaddr in ADDR_W; awvalid in 1; awready out 1
- wdata in DATA_W; wstrb in DATA_W/8; wvalid in 1; wready out 1
- bresp out 2; bvalid out 1; bready in 1
- araddr in ADDR_W; arvalid in 1; arready out 1
- rdata out DATA_W; rresp out 2; rvalid out 1; rready in 1
- frame_start_i  in  1  one-cycle strobe at start of each frame, from timing generator.
- in_vblank_i  in  1  level, high during vertical blanking.
- enable_o  out  1  CTRL[0].
- pattern_sel_o  out  2  CTRL[2:1].
- fb_base_o  out  32  FB_BASE.
- irq_o  out  1  STATUS.frame_irq & CTRL[3]; registered.

Behaviour:
- Reset (rst=1 at posedge):
  - All AXI outputs go to 0: awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata.
  - FSMs return to IDLE.
  - CTRL=0, FB_BASE=FB_BASE_RST, FRAME_CNT=0, frame_irq=0, irq_o=0.
  - Any in-flight transaction is discarded with no response.
- All AXI outputs are registered. awready and arready first rise in the cycle after rst deasserts.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: awready=1. On awvalid&&awready, latch awaddr; next cycle awready=0, wready=1, go to W_DATA.
  - W_DATA: on wvalid&&wready, commit the write and compute bresp; next cycle wready=0, bvalid=1, go to W_RESP.
  - W_RESP: hold bvalid and bresp stable until bready. On handshake, bvalid=0 and awready=1 next cycle, go to W_IDLE.
  - Minimum write latency: AW handshake to bvalid = 2 cycles.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: arready=1. On arvalid&&arready, decode and register rdata and rresp; next cycle arready=0, rvalid=1, go to R_DATA.
  - R_DATA: hold rvalid, rdata and rresp stable until rready. On handshake, rvalid=0 and arready=1 next cycle.
  - Read latency: 1 cycle.
- Read and write FSMs are independent. A read captured on the same edge as a write commit to the same register returns the old value.
- Address map (byte offsets, decoded on addr[7:0], upper bits ignored):
  - 0x00 CTRL, RW: [0] enable, [2:1] pattern, [3] irq_en; other bits read 0.
  - 0x04 STATUS, RO: [0] in_vblank_i (sampled), [1] frame_irq.
  - 0x08 FRAME_CNT, RO: 32-bit counter, +1 per frame_start_i, wraps 0xFFFF_FFFF to 0.
  - 0x0C IRQ_CLR, WO: writing 1 to bit 0 clears frame_irq; reads return 0.
  - 0x10 FB_BASE, RW: full 32 bits.
  - 0x14 ID, RO: returns ID_VALUE.
- Responses:
  - OKAY (2'b00) for valid accesses.
  - SLVERR (2'b10), with no register change, for:
    - addr[1:0]!=0;
    - offset not in the map;
    - write to STATUS, FRAME_CNT or ID;
    - wstrb != all-ones.
  - Error reads return rdata=0.
- frame_irq is set by frame_start_i. If a set and an IRQ_CLR write hit the same cycle, set wins.
- irq_o updates one cycle after frame_irq or CTRL[3] changes.

Decomposition:
- vga_axil_pkg (shared) holds:
  - axil_addr_t, axil_data_t, and axil_resp_e (OKAY, EXOKAY, SLVERR, DECERR);
  - register offset localparams REG_CTRL … REG_ID;
  - packed struct ctrl_reg_t {irq_en, pattern[1:0], enable}.
- One sub-module: vga_axil_regs_decode. Combinational offset decode producing the register select one-hot, is_writable, is_readable and err flags. It is shared by both FSMs.

Test Plan:
- Reset, then write 0x0000_0007 to 0x00 and read 0x00 -> bresp=OKAY, rdata=0x7, rresp=OKAY, enable_o=1, pattern_sel_o=2'b11.
- Write 0x8000_0000 to 0x10, then read 0x10 and read 0x14 -> fb_base_o=0x8000_0000, rdata=0x8000_0000, then 0x5647_4101.
- Pulse frame_start_i 3 times with CTRL=0x8, then read 0x08 and 0x04 -> FRAME_CNT=3, STATUS[1]=1, irq_o=1.
- Write 0x1 to 0x0C in the same cycle as a frame_start_i pulse -> frame_irq stays 1. A second clear with no pulse -> STATUS[1]=0, irq_o=0.
- Write to 0x08, read 0x40, write 0x02 -> each gets SLVERR; reads return rdata=0; FRAME_CNT unchanged.
- Assert rst while in W_RESP with bready=0 -> next cycle bvalid=0, CTRL=0. After release, awready=1 and a new write completes with OKAY.
